// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-port SRAM arbiter: response slot states and port count.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_FRESH = 2'd1,
        SLOT_HELD  = 2'd2
    } sram_slot_state_t;

    localparam integer SRAM_ARB_PORTS = 2;

endpackage

// File: rtl/sram_arb_rsp_slot.sv
// One-deep response slot per port: forwards SRAM rdata the cycle after access,
// or captures it when the response consumer stalls so the data is never lost.
module sram_arb_rsp_slot
    import sram_arbiter_pkg::*;
#(
    parameter int dbits = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grant,
    input  logic             grant_we,
    input  logic             resp_ready,
    input  logic [dbits-1:0] sram_rdata,
    output logic             resp_valid,
    output logic             blocked,
    output logic [dbits-1:0] resp_rdata
);

    sram_slot_state_t state_reg;
    logic             we_reg;
    logic [dbits-1:0] hold_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SLOT_IDLE;
            we_reg    <= 1'b0;
            hold_reg  <= '0;
        end else if (grant) begin
            // A grant is only possible when the previous response leaves this cycle.
            state_reg <= SLOT_FRESH;
            we_reg    <= grant_we;
        end else begin
            case (state_reg)
                SLOT_FRESH: begin
                    if (resp_ready) begin
                        state_reg <= SLOT_IDLE;
                    end else begin
                        state_reg <= SLOT_HELD;
                        hold_reg  <= we_reg ? '0 : sram_rdata;
                    end
                end
                SLOT_HELD: begin
                    if (resp_ready) begin
                        state_reg <= SLOT_IDLE;
                    end
                end
                default: state_reg <= SLOT_IDLE;
            endcase
        end
    end

    assign resp_valid = (state_reg != SLOT_IDLE);
    assign blocked    = resp_valid & ~resp_ready;

    always_comb begin
        resp_rdata = '0;
        case (state_reg)
            SLOT_FRESH: resp_rdata = we_reg ? '0 : sram_rdata;
            SLOT_HELD:  resp_rdata = hold_reg;
            default:    resp_rdata = '0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter2.sv
// Round-robin arbiter sharing one single-port byte-strobed SRAM between two
// requesters; one access per cycle, one in-order response per accepted request.
module sram_arbiter2
    import sram_arbiter_pkg::*;
#(
    parameter  int abits       = 16,
    parameter  int log2_dbytes = 3,
    localparam int dbytes      = 1 << log2_dbytes,
    localparam int dbits       = 8 * dbytes
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [abits-1:0]  i_req0_addr,
    input  logic              i_req0_we,
    input  logic [dbytes-1:0] i_req0_wstrb,
    input  logic [dbits-1:0]  i_req0_wdata,
    output logic              o_resp0_valid,
    input  logic              i_resp0_ready,
    output logic [dbits-1:0]  o_resp0_rdata,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [abits-1:0]  i_req1_addr,
    input  logic              i_req1_we,
    input  logic [dbytes-1:0] i_req1_wstrb,
    input  logic [dbits-1:0]  i_req1_wdata,
    output logic              o_resp1_valid,
    input  logic              i_resp1_ready,
    output logic [dbits-1:0]  o_resp1_rdata,
    output logic [abits-1:0]  o_sram_addr,
    output logic              o_sram_we,
    output logic [dbytes-1:0] o_sram_wstrb,
    output logic [dbits-1:0]  o_sram_wdata,
    input  logic [dbits-1:0]  i_sram_rdata
);

    logic [SRAM_ARB_PORTS-1:0] req_valid, req_we, resp_ready, resp_valid;
    logic [SRAM_ARB_PORTS-1:0] blocked, elig, grant;
    logic [abits-1:0]          req_addr   [SRAM_ARB_PORTS];
    logic [dbytes-1:0]         req_wstrb  [SRAM_ARB_PORTS];
    logic [dbits-1:0]          req_wdata  [SRAM_ARB_PORTS];
    logic [dbits-1:0]          resp_rdata [SRAM_ARB_PORTS];
    logic                      rr_pri_reg;

    assign req_valid    = {i_req1_valid, i_req0_valid};
    assign req_we       = {i_req1_we, i_req0_we};
    assign resp_ready   = {i_resp1_ready, i_resp0_ready};
    assign req_addr[0]  = i_req0_addr;
    assign req_addr[1]  = i_req1_addr;
    assign req_wstrb[0] = i_req0_wstrb;
    assign req_wstrb[1] = i_req1_wstrb;
    assign req_wdata[0] = i_req0_wdata;
    assign req_wdata[1] = i_req1_wdata;

    generate
        for (genvar gi = 0; gi < SRAM_ARB_PORTS; gi++) begin : g_port
            assign elig[gi] = req_valid[gi] & ~blocked[gi];

            sram_arb_rsp_slot #(.dbits(dbits)) u_slot (
                .clk        (i_clk),
                .rst        (i_rst),
                .grant      (grant[gi]),
                .grant_we   (req_we[gi]),
                .resp_ready (resp_ready[gi]),
                .sram_rdata (i_sram_rdata),
                .resp_valid (resp_valid[gi]),
                .blocked    (blocked[gi]),
                .resp_rdata (resp_rdata[gi])
            );
        end
    endgenerate

    // rr_pri_reg names the port that wins when both are eligible.
    always_comb begin
        grant = '0;
        if (!i_rst) begin
            if (elig[0] && (!elig[1] || !rr_pri_reg)) begin
                grant[0] = 1'b1;
            end else if (elig[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_pri_reg <= 1'b0;
        end else if (grant[0]) begin
            rr_pri_reg <= 1'b1;
        end else if (grant[1]) begin
            rr_pri_reg <= 1'b0;
        end
    end

    always_comb begin
        o_sram_addr  = '0;
        o_sram_we    = 1'b0;
        o_sram_wstrb = '0;
        o_sram_wdata = '0;
        for (int p = 0; p < SRAM_ARB_PORTS; p++) begin
            if (grant[p]) begin
                o_sram_addr  = req_addr[p];
                o_sram_we    = req_we[p];
                o_sram_wstrb = req_wstrb[p];
                o_sram_wdata = req_wdata[p];
            end
        end
    end

    assign o_req0_ready  = grant[0];
    assign o_req1_ready  = grant[1];
    assign o_resp0_valid = resp_valid[0];
    assign o_resp1_valid = resp_valid[1];
    assign o_resp0_rdata = resp_rdata[0];
    assign o_resp1_rdata = resp_rdata[1];

endmodule
